ball_motion: RTL and testbench
==============================

# ball_motion

Ball position integrator that sits directly downstream of `velocity_prcs`. It consumes the packed `{vx, vy}` word (`ball_velocity_modified`) and integrates it once per video frame into a ball position on the table. It reflects the ball off the side walls and flags when the ball leaves past either player's end line. Its outputs feed the renderer and the score/serve control.

## Interface
Parameters:
- FIELD_W, 640, table width in whole units (x range 0..FIELD_W)
- FIELD_H, 480, table length in whole units (y range 0..FIELD_H)
- START_X, 320, serve/reset x position, whole units
- START_Y, 240, serve/reset y position, whole units
- OUT_HOLD, 60, frame ticks spent in OUT before returning to IDLE
- GRAVITY, 1, vy increment per frame tick in Q.4 LSBs (only with BALL_GRAVITY_EN)

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle strobe, once per frame
- serve  in  1  one-cycle pulse; starts flight from IDLE
- hit  in  1  one-cycle pulse; paddle contact, reload velocity
- ball_velocity_modified  in  32  [31:16] vx, [15:0] vy; each signed Q11.4
- ball_x  out  16  unsigned Q12.4 position
- ball_y  out  16  unsigned Q12.4 position
- in_flight  out  1  high in FLY
- wall_bounce  out  1  one-cycle pulse on side-wall reflection
- out_top  out  1  one-cycle pulse; ball crossed y=0
- out_bottom  out  1  one-cycle pulse; ball crossed y=FIELD_H

## Operation
- Internal registers: vx_r, vy_r (signed 16), px, py (signed 18, Q.4), hold_cnt (>= clog2(OUT_HOLD+1) bits), state.
- States: IDLE, FLY, OUT.
- IDLE:
  - px/py are held at START_X*16 and START_Y*16.
  - serve=1 → latch vx_r/vy_r from the input and go to FLY.
  - hit is ignored.
- FLY, on frame_tick:
  - nx = px + sext(vx_r), ny = py + sext(vy_r), computed at full 18-bit width.
- X reflection:
  - nx < 0: px = -nx, vx_r = -vx_r, wall_bounce.
  - nx > FIELD_W*16: px = 2*FIELD_W*16 - nx, vx_r = -vx_r, wall_bounce.
  - nx exactly 0 or FIELD_W*16: no bounce.
- Y exit:
  - ny < 0: py = 0, out_top, go to OUT.
  - ny > FIELD_H*16: py = FIELD_H*16, out_bottom, go to OUT.
  - Otherwise py = ny.
  - A bounce and an exit in the same tick both pulse.
- FLY, hit=1:
  - vx_r/vy_r reload from the input.
  - If the same cycle carries frame_tick, the position step uses the old velocity. The hit reload overrides the wall negation and the gravity update.
- FLY, serve: ignored.
- OUT:
  - Position is frozen; hold_cnt counts frame ticks.
  - When hold_cnt reaches OUT_HOLD: go to IDLE, px/py reload to start, hold_cnt = 0.
  - serve and hit are ignored.
- Velocity magnitudes are assumed < FIELD_W*16 per tick. A single tick reflects at most once.

## Timing
- Reset values:
  - ball_x = START_X<<4, ball_y = START_Y<<4.
  - in_flight, wall_bounce, out_top, out_bottom = 0.
  - state IDLE, vx_r = vy_r = 0, hold_cnt = 0.
- All outputs are registered.
- serve at cycle N → in_flight=1 at N+1.
- frame_tick at cycle N → updated ball_x/ball_y and event pulses at N+1. Pulses are exactly one cycle wide.
- State transition to OUT is visible at N+1 together with out_top/out_bottom; in_flight=0 from the same cycle.
- Return to IDLE: in the cycle after the OUT_HOLD-th tick, position shows the start values.
- rst is asynchronous at any time, including mid-flight. All registers go to their reset values immediately, with no pending pulse.
- ball_velocity_modified is sampled only on serve/hit cycles and needs to be stable for that cycle only.

## Configuration
- BALL_GRAVITY_EN defined:
  - Each FLY frame_tick also performs vy_r = vy_r + GRAVITY, saturating at +32767.
  - The update is applied after the position step, so it affects the next tick.
- BALL_GRAVITY_EN undefined: vy_r is constant between serve/hit reloads. The GRAVITY parameter is unused.

## Test plan
- Reset then serve with vx=0x0000, vy=0x00F0 (15.0), one frame_tick → ball_y=0x0FF0 (255.0), ball_x=0x1400, no pulses.
- vx=0xFF00 (-16.0), vy=0, start x=5: one tick → nx=-11 → ball_x=0x00B0 (11.0), vx_r=+16.0, wall_bounce pulse 1 cycle.
- vy=0x1000 (+256.0) from y=240: one tick → y=496>480 → ball_y=0x1E00, out_bottom pulse, in_flight=0. After 60 ticks → ball_x/ball_y = 0x1400/0x0F00, state IDLE.
- hit with vy=-0x0100 (-16.0) on the same cycle as frame_tick while vy_r=+16.0 → the step uses +16.0 (y 240→256). The next tick moves y 256→240.
- Assert rst mid-flight (y=300.0) → ball_y=0x0F00 and in_flight=0 asynchronously. A later tick without serve leaves the position unchanged.
- With BALL_GRAVITY_EN and GRAVITY=16, serve vy=0 → y positions 240, 240, 241, 243 on successive ticks. Without the macro, y stays 240.

Source files
------------

// File: rtl/ball_motion.sv
// Ball position integrator: steps {vx, vy} into a Q12.4 table position once per frame tick, reflects off side walls, flags end-line exits.
// Latency: serve/hit/frame_tick effects appear on the registered outputs one cycle after the input strobe.
// Backpressure: none; strobes are accepted whenever they arrive and are ignored in states that do not use them. Optional feature macro: BALL_GRAVITY_EN.
module ball_motion #(
    parameter int FIELD_W  = 640,
    parameter int FIELD_H  = 480,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int OUT_HOLD = 60,
    parameter int GRAVITY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic        hit,
    input  logic [31:0] ball_velocity_modified,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic        in_flight,
    output logic        wall_bounce,
    output logic        out_top,
    output logic        out_bottom
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int HW = (OUT_HOLD < 1) ? 1 : $clog2(OUT_HOLD + 1);

    localparam logic signed [17:0] X_MAX   = 18'(FIELD_W * 16);
    localparam logic signed [17:0] Y_MAX   = 18'(FIELD_H * 16);
    localparam logic signed [17:0] X_START = 18'(START_X * 16);
    localparam logic signed [17:0] Y_START = 18'(START_Y * 16);

`ifdef BALL_GRAVITY_EN
    localparam bit GRAV_ON = 1'b1;
`else
    localparam bit GRAV_ON = 1'b0;
`endif
    // With gravity disabled the step is zero, so vy_r stays constant between reloads.
    localparam logic signed [16:0] GRAV_STEP = GRAV_ON ? 17'(GRAVITY) : 17'sd0;

    state_t            state;
    logic signed [15:0] vx_r;
    logic signed [15:0] vy_r;
    logic signed [17:0] px;
    logic signed [17:0] py;
    logic [HW-1:0]      hold_cnt;

    logic signed [15:0] vx_in;
    logic signed [15:0] vy_in;
    logic signed [17:0] nx;
    logic signed [17:0] ny;
    logic signed [17:0] nx_refl;
    logic               bounce_lo;
    logic               bounce_hi;
    logic signed [16:0] vy_sum;
    logic signed [15:0] vy_grav;

    assign vx_in  = ball_velocity_modified[31:16];
    assign vy_in  = ball_velocity_modified[15:0];
    assign ball_x = px[15:0];
    assign ball_y = py[15:0];

    // Candidate next position, wall reflection and gravity-adjusted vy for a FLY tick.
    always_comb begin
        nx        = px + 18'(vx_r);
        ny        = py + 18'(vy_r);
        bounce_lo = (nx < 18'sd0);
        bounce_hi = (nx > X_MAX);
        if (bounce_lo) begin
            nx_refl = -nx;
        end else if (bounce_hi) begin
            nx_refl = X_MAX + X_MAX - nx;
        end else begin
            nx_refl = nx;
        end
        vy_sum  = 17'(vy_r) + GRAV_STEP;
        vy_grav = (vy_sum > 17'sd32767) ? 16'sh7FFF : vy_sum[15:0];
    end

    // Flight state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vx_r        <= '0;
            vy_r        <= '0;
            px          <= X_START;
            py          <= Y_START;
            hold_cnt    <= '0;
            in_flight   <= 1'b0;
            wall_bounce <= 1'b0;
            out_top     <= 1'b0;
            out_bottom  <= 1'b0;
        end else begin
            wall_bounce <= 1'b0;
            out_top     <= 1'b0;
            out_bottom  <= 1'b0;
            case (state)
                IDLE: begin
                    px <= X_START;
                    py <= Y_START;
                    if (serve) begin
                        vx_r      <= vx_in;
                        vy_r      <= vy_in;
                        state     <= FLY;
                        in_flight <= 1'b1;
                    end
                end
                FLY: begin
                    if (frame_tick) begin
                        px   <= nx_refl;
                        vy_r <= vy_grav;
                        if (bounce_lo || bounce_hi) begin
                            vx_r        <= -vx_r;
                            wall_bounce <= 1'b1;
                        end
                        if (ny < 18'sd0) begin
                            py        <= '0;
                            out_top   <= 1'b1;
                            state     <= OUT;
                            in_flight <= 1'b0;
                        end else if (ny > Y_MAX) begin
                            py         <= Y_MAX;
                            out_bottom <= 1'b1;
                            state      <= OUT;
                            in_flight  <= 1'b0;
                        end else begin
                            py <= ny;
                        end
                    end
                    // A paddle hit wins over the wall negation and gravity of the same cycle.
                    if (hit) begin
                        vx_r <= vx_in;
                        vy_r <= vy_in;
                    end
                end
                OUT: begin
                    if (frame_tick) begin
                        if (hold_cnt == HW'(OUT_HOLD - 1)) begin
                            state    <= IDLE;
                            px       <= X_START;
                            py       <= Y_START;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_flight <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: the driver queues the expected outputs with each stimulus cycle,
// an independent monitor pops and compares one entry after each clock edge or asynchronous-reset check.
// Velocity is driven with junk on cycles without serve/hit to show it is only sampled on those cycles.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        serve;
    logic        hit;
    logic [31:0] ball_velocity_modified;
    logic [15:0] ball_x;
    logic [15:0] ball_y;
    logic        in_flight;
    logic        wall_bounce;
    logic        out_top;
    logic        out_bottom;

    localparam logic [31:0] J = 32'hDEADBEEF;

    ball_motion #(
        .FIELD_W (640),
        .FIELD_H (480),
        .START_X (320),
        .START_Y (240),
        .OUT_HOLD(60),
        .GRAVITY (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .frame_tick            (frame_tick),
        .serve                 (serve),
        .hit                   (hit),
        .ball_velocity_modified(ball_velocity_modified),
        .ball_x                (ball_x),
        .ball_y                (ball_y),
        .in_flight             (in_flight),
        .wall_bounce           (wall_bounce),
        .out_top               (out_top),
        .out_bottom            (out_bottom)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        fl;
        logic        wb;
        logic        ot;
        logic        ob;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    event  chk_now;

    // Monitor: one expected entry per clock edge that was driven, or per asynchronous check.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk or chk_now);
            #1;
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                nm = nq.pop_front();
                n_cmp++;
                if (ball_x !== e.x || ball_y !== e.y || in_flight !== e.fl ||
                    wall_bounce !== e.wb || out_top !== e.ot || out_bottom !== e.ob) begin
                    n_bad++;
                    $display("FAIL %s: got x=%h y=%h fl=%b wb=%b ot=%b ob=%b, want x=%h y=%h fl=%b wb=%b ot=%b ob=%b",
                             nm, ball_x, ball_y, in_flight, wall_bounce, out_top, out_bottom,
                             e.x, e.y, e.fl, e.wb, e.ot, e.ob);
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected after its clock edge.
    task automatic drv(input logic t, input logic s, input logic h, input logic [31:0] v,
                       input string nm, input logic [15:0] x, input logic [15:0] y,
                       input logic fl, input logic wb, input logic ot, input logic ob);
        @(negedge clk);
        frame_tick             = t;
        serve                  = s;
        hit                    = h;
        ball_velocity_modified = v;
        sb.push_back('{x: x, y: y, fl: fl, wb: wb, ot: ot, ob: ob});
        nq.push_back(nm);
    endtask

    // Queue an expectation to be checked immediately, between clock edges.
    task automatic achk(input string nm, input logic [15:0] x, input logic [15:0] y,
                        input logic fl, input logic wb, input logic ot, input logic ob);
        sb.push_back('{x: x, y: y, fl: fl, wb: wb, ot: ot, ob: ob});
        nq.push_back(nm);
        ->chk_now;
    endtask

    // Clear strobes and assert reset away from both clock edges.
    task automatic async_reset(input string nm);
        @(negedge clk);
        frame_tick = 1'b0;
        serve      = 1'b0;
        hit        = 1'b0;
        #2 rst = 1'b1;
        achk(nm, 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst                    = 1'b1;
        frame_tick             = 1'b0;
        serve                  = 1'b0;
        hit                    = 1'b0;
        ball_velocity_modified = '0;
        repeat (2) @(negedge clk);
        #2 achk("reset_state", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        drv(1'b0, 1'b0, 1'b1, {16'h0000, 16'h0100}, "idle_hit_ignored", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "idle_tick_still", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);

`ifndef BALL_GRAVITY_EN
        // Straight flight, reload by hit, bottom exit and OUT hold.
        drv(1'b0, 1'b1, 1'b0, {16'h0000, 16'h00F0}, "serve_vy15", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "tick_y255", 16'h1400, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b0, {16'h0100, 16'h0100}, "fly_serve_ignored", 16'h1400, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "tick_y270", 16'h1400, 16'h10E0, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, {16'h0000, 16'h1000}, "hit_vy256", 16'h1400, 16'h10E0, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "exit_bottom", 16'h1400, 16'h1E00, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(1'b0, 1'b0, 1'b0, J, "bottom_pulse_end", 16'h1400, 16'h1E00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 59; k++) begin
            drv(1'b1, (k == 10), (k == 20), {16'h0100, 16'h0100}, "out_hold_frozen",
                16'h1400, 16'h1E00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drv(1'b1, 1'b0, 1'b0, J, "out_return_start", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, J, "idle_after_out", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hit coinciding with a tick: the step uses the old velocity.
        drv(1'b0, 1'b1, 1'b0, {16'h0000, 16'h0100}, "serve_vy16", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b1, {16'h0000, 16'hFF00}, "hit_tick_old_vel", 16'h1400, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "tick_new_vel", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Walk left to x=5, then bounce off the left wall.
        drv(1'b0, 1'b0, 1'b1, {16'hFFB0, 16'h0000}, "hit_vx_m5", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 63; k++) begin
            drv(1'b1, 1'b0, 1'b0, J, "walk_left", 16'h1400 - 16'(80 * k), 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drv(1'b0, 1'b0, 1'b1, {16'hFF00, 16'h0000}, "hit_vx_m16", 16'h0050, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "left_bounce", 16'h00B0, 16'h0F00, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, J, "bounce_pulse_end", 16'h00B0, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "after_bounce_vx16", 16'h01B0, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Exact wall positions do not bounce; just past the right wall does.
        drv(1'b0, 1'b0, 1'b1, {16'hFE50, 16'h0000}, "hit_vx_m27", 16'h01B0, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "left_edge_exact", 16'h0000, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, {16'h27F0, 16'h0000}, "hit_vx_p639", 16'h0000, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "near_right", 16'h27F0, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, {16'h0020, 16'h0000}, "hit_vx_p2", 16'h27F0, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "right_bounce", 16'h27F0, 16'h0F00, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, {16'h0010, 16'h0000}, "hit_vx_p1", 16'h27F0, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "right_edge_exact", 16'h2800, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Bounce and top exit on the same tick.
        drv(1'b0, 1'b0, 1'b1, {16'h0100, 16'hF000}, "hit_vx16_vym256", 16'h2800, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "bounce_and_top", 16'h2700, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 1'b0, J, "top_pulse_end", 16'h2700, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset from OUT and from mid-flight.
        async_reset("rst_in_out");
        drv(1'b0, 1'b1, 1'b0, {16'h0000, 16'h03C0}, "serve_vy60", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "tick_y300", 16'h1400, 16'h12C0, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset("rst_mid_flight");
        drv(1'b1, 1'b0, 1'b0, J, "tick_after_rst", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, {16'h0000, 16'h0100}, "hit_after_rst", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "tick2_after_rst", 16'h1400, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Zero-velocity serve: constant y without gravity, accelerating with it (GRAVITY=16 -> +1.0/tick).
        drv(1'b0, 1'b1, 1'b0, {16'h0000, 16'h0000}, "serve_still", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef BALL_GRAVITY_EN
        drv(1'b1, 1'b0, 1'b0, J, "grav_tick1", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "grav_tick2", 16'h1400, 16'h0F10, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "grav_tick3", 16'h1400, 16'h0F30, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, J, "final_idle", 16'h1400, 16'h0F30, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        drv(1'b1, 1'b0, 1'b0, J, "still_tick1", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "still_tick2", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, J, "still_tick3", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, J, "final_idle", 16'h1400, 16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
